// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
// Walks IDLE -> REQ -> ISSUE -> REQ ... and drives the pc fetch/jump strobes.
// It runs the request/acknowledge handshake with instruction memory and
// presents the latched instruction to decode with a valid/ready handshake.
// Branch redirects from execute take effect only at hand-off; a misaligned
// target parks the sequencer in ERR until reset.
// Optional feature macro: FETCH_TIMEOUT_EN. When it is defined, a request
// left unacknowledged for MEM_TIMEOUT cycles also enters ERR.
module fetch_ctrl #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_addr,
   output logic        fetch_flag,
   output logic        jmp_flag,
   output logic [31:0] offset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] instr_addr,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_offset,
   output logic        fetch_err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_ISSUE = 2'd2,
      S_ERR   = 2'd3
   } state_t;

   state_t state;
   logic   handoff;
   logic   misaligned;

`ifdef FETCH_TIMEOUT_EN
   localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
   // Unacknowledged REQ cycles seen so far in the current request.
   logic [CNT_W-1:0] wait_cnt;
`endif

   // Memory side: the request and its address are pure decodes of the state,
   // so an asynchronous reset drops imem_req without waiting for a clock.
   assign imem_req   = (state == S_REQ);
   assign imem_addr  = imem_req ? i_addr : 32'h0;
   assign fetch_flag = imem_req & imem_ack;

   // Decode side: an instruction is handed off when valid meets ready.
   assign instr_valid = (state == S_ISSUE);
   assign handoff     = instr_valid & instr_ready;

   // Redirects only matter on the hand-off cycle. At that point pc already
   // holds instr_addr+4, so pc applying offset-4 lands exactly on the target.
   assign misaligned = (redirect_offset[1:0] != 2'b00);
   assign jmp_flag   = handoff & redirect & ~misaligned;
   assign offset     = jmp_flag ? redirect_offset : 32'h0;

   // Error is sticky because ERR has no exit other than reset.
   assign fetch_err = (state == S_ERR);

   // Sequencer state, instruction latch and optional request wait counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         instr      <= 32'h0;
         instr_addr <= 32'h0;
`ifdef FETCH_TIMEOUT_EN
         wait_cnt   <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               // Single settling cycle after reset; a stray ack is ignored.
               state <= S_REQ;
`ifdef FETCH_TIMEOUT_EN
               wait_cnt <= '0;
`endif
            end
            S_REQ: begin
               if (imem_ack) begin
                  // rdata is only valid in the ack cycle, so capture it now.
                  instr      <= imem_rdata;
                  instr_addr <= i_addr;
                  state      <= S_ISSUE;
               end
`ifdef FETCH_TIMEOUT_EN
               // An ack on the final allowed cycle takes priority above.
               else if (wait_cnt == CNT_LAST) begin
                  state <= S_ERR;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            S_ISSUE: begin
               // Without a hand-off the latch holds and redirect is ignored.
               if (handoff) begin
                  if (redirect && misaligned) begin
                     state <= S_ERR;
                  end else begin
                     state <= S_REQ;
                  end
`ifdef FETCH_TIMEOUT_EN
                  wait_cnt <= '0;
`endif
               end
            end
            default: begin
               state <= S_ERR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: bench for fetch_ctrl.
// A small pc model closes the loop on fetch_flag/jmp_flag. A directed vector
// table covers the sequential corner cases, and a randomized run is checked
// against a transaction-level reference model that tracks the held
// instruction, the next fetch address and the sticky error.
// Define FETCH_TIMEOUT_EN to build and check the timeout variant.
module tb_fetch_ctrl;

   localparam int TMO = 15;

   logic        clk;
   logic        rst;
   logic [31:0] pc;
   logic        fetch_flag;
   logic        jmp_flag;
   logic [31:0] offset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] instr_addr;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect;
   logic [31:0] redirect_offset;
   logic        fetch_err;

   int checks   = 0;
   int failures = 0;
   int cyc_no   = 0;

   fetch_ctrl #(.MEM_TIMEOUT(TMO)) dut (
      .clk             (clk),
      .rst             (rst),
      .i_addr          (pc),
      .fetch_flag      (fetch_flag),
      .jmp_flag        (jmp_flag),
      .offset          (offset),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ack        (imem_ack),
      .imem_rdata      (imem_rdata),
      .instr           (instr),
      .instr_addr      (instr_addr),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .redirect        (redirect),
      .redirect_offset (redirect_offset),
      .fetch_err       (fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Program counter as the core implements it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)             pc <= 32'h0;
      else if (fetch_flag) pc <= pc + 32'd4;
      else if (jmp_flag)   pc <= pc + offset - 32'd4;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic        ack;
      logic [31:0] rd;
      logic        rdy;
      logic        rr;
      logic [31:0] ro;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_fetch;
      logic        e_valid;
      logic        e_jmp;
      logic [31:0] e_off;
      logic        e_err;
      logic [31:0] e_instr;
      logic [31:0] e_iaddr;
   } vec_t;

   // Reference model: what the fetch unit should be holding and doing.
   bit          m_boot;
   bit          m_have;
   bit          m_err;
   logic [31:0] m_instr;
   logic [31:0] m_addr;
   logic [31:0] m_next_pc;
   int          m_wait;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc_no, act, exp);
      end
   endtask

   function automatic vec_t mk(logic a, logic [31:0] rd, logic r, logic rr, logic [31:0] ro,
                               logic er, logic [31:0] ea, logic ef, logic ev, logic ej,
                               logic [31:0] eo, logic ee, logic [31:0] ei, logic [31:0] eia);
      vec_t v;
      v.ack = a; v.rd = rd; v.rdy = r; v.rr = rr; v.ro = ro;
      v.e_req = er; v.e_addr = ea; v.e_fetch = ef; v.e_valid = ev; v.e_jmp = ej;
      v.e_off = eo; v.e_err = ee; v.e_instr = ei; v.e_iaddr = eia;
      return v;
   endfunction

   task automatic model_reset();
      m_boot = 1; m_have = 0; m_err = 0;
      m_instr = 32'h0; m_addr = 32'h0; m_next_pc = 32'h0; m_wait = 0;
   endtask

   // Compare current outputs with the model, then advance the model by one cycle.
   task automatic model_eval();
      bit          e_req, e_fetch, e_valid, hand, aligned, e_jmp;
      e_req   = !m_err && !m_boot && !m_have;
      e_fetch = e_req && imem_ack;
      e_valid = !m_err && m_have;
      hand    = e_valid && instr_ready;
      aligned = (redirect_offset[1:0] == 2'b00);
      e_jmp   = hand && redirect && aligned;
      chk("m_imem_req", 32'(imem_req), 32'(e_req));
      chk("m_imem_addr", imem_addr, e_req ? m_next_pc : 32'h0);
      chk("m_fetch_flag", 32'(fetch_flag), 32'(e_fetch));
      chk("m_instr_valid", 32'(instr_valid), 32'(e_valid));
      chk("m_jmp_flag", 32'(jmp_flag), 32'(e_jmp));
      chk("m_offset", offset, e_jmp ? redirect_offset : 32'h0);
      chk("m_fetch_err", 32'(fetch_err), 32'(m_err));
      if (e_valid) begin
         chk("m_instr", instr, m_instr);
         chk("m_instr_addr", instr_addr, m_addr);
      end
      if (m_boot) begin
         m_boot = 0;
      end else if (e_req) begin
         if (imem_ack) begin
            m_have = 1; m_instr = imem_rdata; m_addr = m_next_pc;
            m_next_pc = m_next_pc + 32'd4; m_wait = 0;
         end else begin
`ifdef FETCH_TIMEOUT_EN
            m_wait++;
            if (m_wait >= TMO) m_err = 1;
`endif
         end
      end else if (hand) begin
         m_have = 0; m_wait = 0;
         if (redirect) begin
            if (aligned) m_next_pc = m_addr + redirect_offset;
            else         m_err = 1;
         end
      end
   endtask

   // Called at posedge+1: drive inputs, check before the next edge, advance.
   task automatic run_cycle(input vec_t v, input bit tbl);
      imem_ack = v.ack; imem_rdata = v.rd; instr_ready = v.rdy;
      redirect = v.rr; redirect_offset = v.ro;
      #4;
      if (tbl) begin
         chk("t_imem_req", 32'(imem_req), 32'(v.e_req));
         chk("t_imem_addr", imem_addr, v.e_addr);
         chk("t_fetch_flag", 32'(fetch_flag), 32'(v.e_fetch));
         chk("t_instr_valid", 32'(instr_valid), 32'(v.e_valid));
         chk("t_jmp_flag", 32'(jmp_flag), 32'(v.e_jmp));
         chk("t_offset", offset, v.e_off);
         chk("t_fetch_err", 32'(fetch_err), 32'(v.e_err));
         if (v.e_valid) begin
            chk("t_instr", instr, v.e_instr);
            chk("t_instr_addr", instr_addr, v.e_iaddr);
         end
      end
      model_eval();
      @(posedge clk);
      #1;
      cyc_no++;
   endtask

   // Asynchronous reset from mid-cycle; outputs must clear without a clock.
   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_imem_req", 32'(imem_req), 32'h0);
      chk("rst_imem_addr", imem_addr, 32'h0);
      chk("rst_instr_valid", 32'(instr_valid), 32'h0);
      chk("rst_fetch_err", 32'(fetch_err), 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_instr_addr", instr_addr, 32'h0);
      imem_ack = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   vec_t tbl[$];
   vec_t rv;

   initial begin
      rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
      redirect = 1'b0; redirect_offset = 32'h0;

      //        ack rdata          rdy rr ro            req addr   fetch vld jmp off           err instr          iaddr
      tbl.push_back(mk(1, 32'hDEAD0000, 1, 0, 32'h0,        0, 32'h00, 0, 0, 0, 32'h0,        0, 32'h0,        32'h00));
      tbl.push_back(mk(1, 32'h11110000, 1, 0, 32'h0,        1, 32'h00, 1, 0, 0, 32'h0,        0, 32'h0,        32'h00));
      tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 32'h00, 0, 1, 0, 32'h0,        0, 32'h11110000, 32'h00));
      tbl.push_back(mk(1, 32'h11110004, 1, 0, 32'h0,        1, 32'h04, 1, 0, 0, 32'h0,        0, 32'h0,        32'h00));
      tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 32'h00, 0, 1, 0, 32'h0,        0, 32'h11110004, 32'h04));
      tbl.push_back(mk(0, 32'hBAD00001, 1, 0, 32'h0,        1, 32'h08, 0, 0, 0, 32'h0,        0, 32'h0,        32'h00));
      tbl.push_back(mk(0, 32'hBAD00002, 1, 0, 32'h0,        1, 32'h08, 0, 0, 0, 32'h0,        0, 32'h0,        32'h00));
      tbl.push_back(mk(0, 32'hBAD00003, 1, 0, 32'h0,        1, 32'h08, 0, 0, 0, 32'h0,        0, 32'h0,        32'h00));
      tbl.push_back(mk(1, 32'h11110008, 1, 0, 32'h0,        1, 32'h08, 1, 0, 0, 32'h0,        0, 32'h0,        32'h00));
      tbl.push_back(mk(0, 32'h0,        0, 1, 32'h6,        0, 32'h00, 0, 1, 0, 32'h0,        0, 32'h11110008, 32'h08));
      tbl.push_back(mk(1, 32'h0,        0, 0, 32'hFFFFFFF8, 0, 32'h00, 0, 1, 0, 32'h0,        0, 32'h11110008, 32'h08));
      tbl.push_back(mk(0, 32'h0,        0, 1, 32'hFFFFFFF8, 0, 32'h00, 0, 1, 0, 32'h0,        0, 32'h11110008, 32'h08));
      tbl.push_back(mk(1, 32'h0,        0, 0, 32'h0,        0, 32'h00, 0, 1, 0, 32'h0,        0, 32'h11110008, 32'h08));
      tbl.push_back(mk(0, 32'h0,        0, 1, 32'h0,        0, 32'h00, 0, 1, 0, 32'h0,        0, 32'h11110008, 32'h08));
      tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 32'h00, 0, 1, 0, 32'h0,        0, 32'h11110008, 32'h08));
      tbl.push_back(mk(1, 32'h1111000C, 1, 0, 32'h0,        1, 32'h0C, 1, 0, 0, 32'h0,        0, 32'h0,        32'h00));
      tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 32'h00, 0, 1, 0, 32'h0,        0, 32'h1111000C, 32'h0C));
      tbl.push_back(mk(1, 32'h11110010, 1, 0, 32'h0,        1, 32'h10, 1, 0, 0, 32'h0,        0, 32'h0,        32'h00));
      tbl.push_back(mk(0, 32'h0,        1, 1, 32'hFFFFFFF8, 0, 32'h00, 0, 1, 1, 32'hFFFFFFF8, 0, 32'h11110010, 32'h10));
      tbl.push_back(mk(1, 32'h22220008, 1, 0, 32'h0,        1, 32'h08, 1, 0, 0, 32'h0,        0, 32'h0,        32'h00));
      tbl.push_back(mk(0, 32'h0,        1, 1, 32'h6,        0, 32'h00, 0, 1, 0, 32'h0,        0, 32'h22220008, 32'h08));
      tbl.push_back(mk(1, 32'h0,        1, 1, 32'h0,        0, 32'h00, 0, 0, 0, 32'h0,        1, 32'h0,        32'h00));
      tbl.push_back(mk(1, 32'h0,        1, 0, 32'h0,        0, 32'h00, 0, 0, 0, 32'h0,        1, 32'h0,        32'h00));
      tbl.push_back(mk(1, 32'h0,        1, 1, 32'h4,        0, 32'h00, 0, 0, 0, 32'h0,        1, 32'h0,        32'h00));

      do_reset();
      foreach (tbl[i]) run_cycle(tbl[i], 1'b1);

      // Reset while a request is pending, then a late ack in IDLE.
      do_reset();
      rv = mk(0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0);
      repeat (3) run_cycle(rv, 1'b0);
      chk("pending_req_before_rst", 32'(imem_req), 32'h1);
      do_reset();
      rv.ack = 1'b1; rv.rd = 32'h33330000;
      run_cycle(rv, 1'b0);
      chk("refetch_addr_after_rst", imem_addr, 32'h0);
      chk("refetch_req_after_rst", 32'(imem_req), 32'h1);
      run_cycle(rv, 1'b0);

`ifdef FETCH_TIMEOUT_EN
      // Memory never answers: error after exactly TMO request cycles.
      do_reset();
      rv = mk(0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0);
      run_cycle(rv, 1'b0);
      for (int k = 0; k < TMO; k++) begin
         chk("tmo_req_held", 32'(imem_req), 32'h1);
         chk("tmo_no_err_yet", 32'(fetch_err), 32'h0);
         run_cycle(rv, 1'b0);
      end
      chk("tmo_err", 32'(fetch_err), 32'h1);
      chk("tmo_req_dropped", 32'(imem_req), 32'h0);
      run_cycle(rv, 1'b0);
      // Ack on the last allowed cycle still completes the fetch.
      do_reset();
      run_cycle(rv, 1'b0);
      for (int k = 0; k < TMO - 1; k++) run_cycle(rv, 1'b0);
      rv.ack = 1'b1; rv.rd = 32'h44440000;
      run_cycle(rv, 1'b0);
      chk("tmo_late_ack_valid", 32'(instr_valid), 32'h1);
      chk("tmo_late_ack_err", 32'(fetch_err), 32'h0);
`endif

      // Randomized traffic against the reference model.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         if ((m_err && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
            do_reset();
         end
         rv.ack   = ($urandom_range(0, 2) != 0);
         rv.rd    = $urandom;
         rv.rdy   = ($urandom_range(0, 3) != 0);
         rv.rr    = ($urandom_range(0, 3) == 0);
         rv.ro    = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 19) == 0) rv.ro = rv.ro | 32'($urandom_range(1, 3));
         run_cycle(rv, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
